mem_rmw_arbiter: RTL and testbench
==================================

# mem_rmw_arbiter

Two-requester arbiter and sequencer for a shared single-port word memory (DEPTH words × N bits) held inside the block. Each requester issues word reads, full-word writes or byte-lane (sub-word) writes. Sub-word writes run as an internal read-modify-write, so requesters never merge lanes themselves. Round-robin arbitration; one transaction in flight at a time.

## Interface
- N, 32, data word width; multiple of 8
- AW, 10, address width
- DEPTH, 1024, words in array; addresses 0..DEPTH-1
- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- a_req  in  1  requester A transaction request; held until a_ack
- a_we  in  1  A: 1 = write, 0 = read
- a_addr  in  AW  A word address
- a_be  in  N/8  A byte-lane enables; bit i covers data bits 8i+7:8i
- a_wdata  in  N  A write data (lane-aligned)
- a_ack  out  1  A one-cycle completion pulse
- a_rdata  out  N  A result word, valid while a_ack=1
- b_req, b_we, b_addr, b_be, b_wdata, b_ack, b_rdata: same as A for requester B
- busy  out  1  high whenever state ≠ IDLE

## Operation
- States: IDLE, RD, WR, ACK.
- IDLE: if any req, latch winner's we/addr/be/wdata into request registers, record owner, set last_winner=owner.
  - Arbitration: only one req → that one; both → the one ≠ last_winner. last_winner resets to B, so A wins the first tie.
  - Next state: read or (write with be=0) → RD; write with be all-ones → WR; other write → RD.
- RD: hold <= mem[addr]. Next: WR if write with be≠0, else ACK.
- WR: merged = for each lane i, be[i] ? wdata lane : hold lane (full write ignores hold); mem[addr] <= merged; hold <= merged. Next ACK.
- ACK: owner's ack=1, owner's rdata=hold; other requester's ack=0. Next IDLE.
- Result word: read → stored word; write → word as stored after the write; be=0 write → unchanged stored word, no memory write.
- Requester must hold all inputs stable from req rise through its ack cycle. req still high in the cycle after ack = new transaction, arbitrated normally in IDLE.
- Changes on a non-owner's inputs during a transaction have no effect.
- Reset (async, any state): state=IDLE, a_ack=b_ack=0, a_rdata=b_rdata=0, busy=0, hold=0, last_winner=B. Memory contents not cleared. An operation interrupted before its WR edge performs no write; the interrupted requester gets no ack and must re-issue.

## Timing
- Edge 0 = IDLE edge sampling req. ack high during cycle after edge L.
- Read / be=0 write: L=2 (RD, ACK). Full write: L=2 (WR, ACK). Partial write: L=3 (RD, WR, ACK).
- Back-to-back: IDLE costs one cycle between transactions. Min period 3 cycles (read/full write), 4 (partial).
- Outputs registered or decoded from state/owner registers only; no combinational path from req to ack/rdata.
- a_rdata/b_rdata hold value outside ack cycles; only the ack cycle is defined.
- Write becomes visible to any transaction granted after its ack.

## Test plan
- Reset: rst_n low mid-clock → a_ack=b_ack=0, busy=0, rdata=0 immediately, without waiting for a clk edge.
- A full write addr 0, be=4'hF, wdata 32'h12345678 → a_ack 2 cycles after grant; A read addr 0 → a_rdata=32'h12345678, L=2.
- A partial write addr 0, be=4'b0100, wdata 32'h00AA0000 → L=3, a_rdata=32'h12AA5678; B read addr 0 → 32'h12AA5678.
- B write be=4'h0 addr 0 wdata 32'hFFFFFFFF → b_rdata=32'h12AA5678, memory unchanged on re-read.
- a_req and b_req both high continuously after reset, all reads → acks alternate A, B, A, B, 3 cycles apart; never two acks in one cycle.
- Partial write in progress, rst_n pulsed low during RD → no ack, busy=0; after release, read addr → previous contents.

Source files
------------

// File: rtl/mem_rmw_arbiter.sv
// mem_rmw_arbiter: two-requester round-robin arbiter and sequencer in front of
// an internal single-port word memory. Sub-word writes run as a
// read-modify-write, so requesters can issue byte-lane writes directly.
// One transaction is in flight at a time. Acks and result words are
// registered, so no combinational path runs from a request to its ack.

module mem_rmw_arbiter #(
  parameter int N     = 32,
  parameter int AW    = 10,
  parameter int DEPTH = 1024
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           a_req,
  input  logic           a_we,
  input  logic [AW-1:0]  a_addr,
  input  logic [N/8-1:0] a_be,
  input  logic [N-1:0]   a_wdata,
  output logic           a_ack,
  output logic [N-1:0]   a_rdata,
  input  logic           b_req,
  input  logic           b_we,
  input  logic [AW-1:0]  b_addr,
  input  logic [N/8-1:0] b_be,
  input  logic [N-1:0]   b_wdata,
  output logic           b_ack,
  output logic [N-1:0]   b_rdata,
  output logic           busy
);

  localparam int BW = N / 8;

  typedef enum logic [1:0] {IDLE, RD, WR, ACK} state_t;

  state_t         state;
  logic           owner_b;    // 1: requester B owns the transaction in flight
  logic           last_b;     // 1: B won the most recent grant
  logic           req_we;
  logic [AW-1:0]  req_addr;
  logic [BW-1:0]  req_be;
  logic [N-1:0]   req_wdata;
  logic [N-1:0]   hold;       // word read from memory, then the merged result
  logic [N-1:0]   merged;

  logic           grant_b;
  logic           sel_we;
  logic [AW-1:0]  sel_addr;
  logic [BW-1:0]  sel_be;
  logic [N-1:0]   sel_wdata;

  logic [N-1:0]   mem [DEPTH];

  // Round-robin grant: a lone request wins; a tie goes to whoever did not win last.
  always_comb begin
    grant_b   = b_req && (!a_req || !last_b);
    sel_we    = grant_b ? b_we    : a_we;
    sel_addr  = grant_b ? b_addr  : a_addr;
    sel_be    = grant_b ? b_be    : a_be;
    sel_wdata = grant_b ? b_wdata : a_wdata;
  end

  // Lane merge: enabled lanes take the write data, the rest keep the stored word.
  always_comb begin
    // NOTE: the full default assignment comes first so no path leaves merged unassigned (no latch).
    merged = hold;
    for (int i = 0; i < BW; i++) begin
      if (req_be[i]) merged[8*i +: 8] = req_wdata[8*i +: 8];
    end
  end

  assign busy = (state != IDLE);

  // Sequencer: grant in IDLE, read for reads and partial writes, write, then ack.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: all state here uses non-blocking assignments so every register sees pre-edge values.
    if (!rst_n) begin
      state     <= IDLE;
      owner_b   <= 1'b0;
      last_b    <= 1'b1;
      req_we    <= 1'b0;
      req_addr  <= '0;
      req_be    <= '0;
      req_wdata <= '0;
      hold      <= '0;
      a_ack     <= 1'b0;
      b_ack     <= 1'b0;
      a_rdata   <= '0;
      b_rdata   <= '0;
    end else begin
      a_ack <= 1'b0;
      b_ack <= 1'b0;
      case (state)
        IDLE: begin
          if (a_req || b_req) begin
            owner_b   <= grant_b;
            last_b    <= grant_b;
            req_we    <= sel_we;
            req_addr  <= sel_addr;
            req_be    <= sel_be;
            req_wdata <= sel_wdata;
            // A full-word write needs nothing from memory, so it skips the read.
            state     <= (sel_we && (sel_be == '1)) ? WR : RD;
          end
        end
        RD: begin
          hold  <= mem[req_addr];
          state <= (req_we && (req_be != '0)) ? WR : ACK;
        end
        WR: begin
          hold  <= merged;
          state <= ACK;
        end
        ACK: begin
          if (owner_b) begin
            b_ack   <= 1'b1;
            b_rdata <= hold;
          end else begin
            a_ack   <= 1'b1;
            a_rdata <= hold;
          end
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Memory write port: commits the merged word on the WR edge only.
  // NOTE: the array is deliberately left out of reset; contents survive rst_n.
  always_ff @(posedge clk) begin
    if (state == WR) mem[req_addr] <= merged;
  end

endmodule

// File: tb/tb_mem_rmw_arbiter.sv
// Self-checking bench for mem_rmw_arbiter. A transaction-level model keeps a
// word array, the round-robin pointer and the grant/ack timing as plain
// cycle arithmetic; a single compare step checks busy, both acks and the
// acked result word on every cycle. Directed transactions also carry
// hand-computed result words and latencies.

module tb_mem_rmw_arbiter;

  localparam int N     = 32;
  localparam int AW    = 10;
  localparam int DEPTH = 1024;
  localparam int BW    = N / 8;

  typedef struct {
    bit          we;
    bit [AW-1:0] addr;
    bit [BW-1:0] be;
    bit [N-1:0]  wdata;
    int          gap;
    bit          has_lit;
    bit [N-1:0]  lit;
    int          lit_lat;
  } txn_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          a_req, a_we, b_req, b_we;
  logic [AW-1:0] a_addr, b_addr;
  logic [BW-1:0] a_be, b_be;
  logic [N-1:0]  a_wdata, b_wdata, a_rdata, b_rdata;
  logic          a_ack, b_ack, busy;

  always #5 clk = ~clk;

  mem_rmw_arbiter #(.N(N), .AW(AW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_be(a_be), .a_wdata(a_wdata),
    .a_ack(a_ack), .a_rdata(a_rdata),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_be(b_be), .b_wdata(b_wdata),
    .b_ack(b_ack), .b_rdata(b_rdata),
    .busy(busy)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state
  bit [N-1:0]  mem_m [DEPTH];
  int          cyc = 0;
  bit          m_active;
  int          m_owner;
  int          m_last;
  int          g_edge;
  int          m_L;
  bit [N-1:0]  m_result;
  bit          m_pend_wr;
  bit [AW-1:0] m_wr_addr;
  bit          exp_ack [2];
  bit [N-1:0]  exp_rdata [2];

  // Requester drivers
  txn_t q0[$];
  txn_t q1[$];
  txn_t cur [2];
  bit   pend [2];
  int   wait_cnt [2];

  // Round-robin pattern tracking
  bit rr_mode;
  int rr_n;
  int rr_prev;
  int rr_prev_cyc;

  task automatic check(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic txn_t mk(input bit we, input int addr, input bit [BW-1:0] be,
                              input bit [N-1:0] wdata, input int gap,
                              input bit has_lit, input bit [N-1:0] lit, input int lat);
    txn_t t;
    t.we = we; t.addr = AW'(addr); t.be = be; t.wdata = wdata; t.gap = gap;
    t.has_lit = has_lit; t.lit = lit; t.lit_lat = lat;
    return t;
  endfunction

  function automatic bit [N-1:0] lane_merge(input bit [N-1:0] old, input bit [N-1:0] wd,
                                            input bit [BW-1:0] be);
    bit [N-1:0] r;
    r = old;
    for (int i = 0; i < BW; i++) if (be[i]) r[8*i +: 8] = wd[8*i +: 8];
    return r;
  endfunction

  task automatic model_reset();
    m_active = 0; m_pend_wr = 0; m_last = 1;
    exp_ack[0] = 0; exp_ack[1] = 0;
    exp_rdata[0] = '0; exp_rdata[1] = '0;
    pend[0] = 0; pend[1] = 0; wait_cnt[0] = 0; wait_cnt[1] = 0;
    q0.delete(); q1.delete();
  endtask

  // Advance the model by one rising edge, using the requests held before it.
  task automatic model_edge();
    int   w;
    txn_t t;
    bit [N-1:0] old;
    cyc++;
    exp_ack[0] = 0; exp_ack[1] = 0;
    if (m_active) begin
      if (m_pend_wr && cyc == g_edge + m_L - 1) begin
        mem_m[m_wr_addr] = m_result;
        m_pend_wr = 0;
      end
      if (cyc == g_edge + m_L) begin
        exp_ack[m_owner]   = 1;
        exp_rdata[m_owner] = m_result;
        m_active = 0;
      end
    end else if (pend[0] || pend[1]) begin
      if (pend[0] && pend[1]) w = (m_last == 0) ? 1 : 0;
      else                    w = pend[0] ? 0 : 1;
      t = cur[w];
      m_last = w; m_owner = w; g_edge = cyc; m_active = 1;
      old = mem_m[t.addr];
      m_result  = t.we ? lane_merge(old, t.wdata, t.be) : old;
      m_pend_wr = t.we && (t.be != '0);
      m_wr_addr = t.addr;
      m_L = (t.we && t.be != '0 && t.be != '1) ? 3 : 2;
    end
  endtask

  task automatic compare();
    int who;
    check("busy", busy, m_active);
    check("a_ack", a_ack, exp_ack[0]);
    check("b_ack", b_ack, exp_ack[1]);
    if (exp_ack[0]) check("a_rdata", a_rdata, exp_rdata[0]);
    if (exp_ack[1]) check("b_rdata", b_rdata, exp_rdata[1]);
    for (int r = 0; r < 2; r++) begin
      if (exp_ack[r] && cur[r].has_lit) begin
        check("lit_rdata", (r == 0) ? a_rdata : b_rdata, cur[r].lit);
        check("lit_latency", m_L, cur[r].lit_lat);
      end
    end
    if (rr_mode && (a_ack || b_ack)) begin
      check("single_ack", a_ack && b_ack, 0);
      who = b_ack ? 1 : 0;
      if (rr_n == 0) begin
        check("rr_first_owner", who, 0);
      end else begin
        check("rr_alternate", who, 1 - rr_prev);
        check("rr_spacing", cyc - rr_prev_cyc, 3);
      end
      rr_prev = who; rr_prev_cyc = cyc; rr_n++;
    end
  endtask

  task automatic drive();
    for (int r = 0; r < 2; r++) begin
      if (exp_ack[r]) begin
        pend[r] = 0;
        wait_cnt[r] = cur[r].gap;
      end
      if (!pend[r]) begin
        if (wait_cnt[r] > 0) wait_cnt[r]--;
        else if (r == 0 && q0.size() > 0) begin cur[0] = q0.pop_front(); pend[0] = 1; end
        else if (r == 1 && q1.size() > 0) begin cur[1] = q1.pop_front(); pend[1] = 1; end
      end
    end
    a_req = pend[0];
    if (pend[0]) begin
      a_we = cur[0].we; a_addr = cur[0].addr; a_be = cur[0].be; a_wdata = cur[0].wdata;
    end else begin
      a_we = 1'($urandom); a_addr = AW'($urandom); a_be = BW'($urandom); a_wdata = $urandom;
    end
    b_req = pend[1];
    if (pend[1]) begin
      b_we = cur[1].we; b_addr = cur[1].addr; b_be = cur[1].be; b_wdata = cur[1].wdata;
    end else begin
      b_we = 1'($urandom); b_addr = AW'($urandom); b_be = BW'($urandom); b_wdata = $urandom;
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    if (rst_n) model_edge();
    @(negedge clk);
    compare();
    drive();
  endtask

  task automatic run_until_idle(input int budget);
    int k;
    k = 0;
    while ((q0.size() > 0 || q1.size() > 0 || pend[0] || pend[1] || m_active) && k < budget) begin
      cycle();
      k++;
    end
    if (k >= budget) begin
      n_cmp++; n_bad++;
      $display("FAIL drain_timeout: got %0d cycles, expected under %0d", k, budget);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_a_ack"}, a_ack, 0);
    check({tag, "_b_ack"}, b_ack, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_a_rdata"}, a_rdata, 0);
    check({tag, "_b_rdata"}, b_rdata, 0);
  endtask

  initial begin
    txn_t t;
    model_reset();
    drive();
    rr_mode = 0;

    // Power-on reset
    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_outputs("por");
    rst_n = 1'b1;

    // Directed: full write, read back, partial write, cross-requester read, be=0 write
    q0.push_back(mk(1, 0, 4'hF, 32'h1234_5678, 1, 1, 32'h1234_5678, 2));
    q0.push_back(mk(0, 0, 4'h0, 32'h0,          1, 1, 32'h1234_5678, 2));
    q0.push_back(mk(1, 0, 4'b0100, 32'h00AA_0000, 1, 1, 32'h12AA_5678, 3));
    run_until_idle(100);
    q1.push_back(mk(0, 0, 4'h0, 32'h0,          1, 1, 32'h12AA_5678, 2));
    q1.push_back(mk(1, 0, 4'h0, 32'hFFFF_FFFF, 1, 1, 32'h12AA_5678, 2));
    q1.push_back(mk(0, 0, 4'h0, 32'h0,          1, 1, 32'h12AA_5678, 2));
    run_until_idle(100);

    // Fill addresses 1..7 so every later read has a defined word
    for (int i = 1; i < 8; i++)
      q0.push_back(mk(1, i, 4'hF, {8'hC0, 8'(i), 16'hBEEF}, 0, 1, {8'hC0, 8'(i), 16'hBEEF}, 2));
    run_until_idle(200);

    // Partial write interrupted by reset while reading: no ack, no write
    q0.push_back(mk(1, 3, 4'b0010, 32'h0000_5A00, 0, 0, 32'h0, 0));
    cycle();
    cycle();
    check("rmw_busy_before_reset", busy, 1);
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("async");
    model_reset();
    drive();
    @(posedge clk);
    @(negedge clk);
    check_reset_outputs("held");
    rst_n = 1'b1;

    // Both requesters reading continuously right after reset: A, B, A, B ...
    rr_mode = 1; rr_n = 0;
    for (int i = 0; i < 6; i++) begin
      q0.push_back(mk(0, $urandom_range(0, 7), 4'h0, 32'h0, 0, 0, 32'h0, 0));
      q1.push_back(mk(0, $urandom_range(0, 7), 4'h0, 32'h0, 0, 0, 32'h0, 0));
    end
    run_until_idle(200);
    rr_mode = 0;
    check("rr_ack_count", rr_n, 12);

    // The interrupted write left address 3 untouched
    q0.push_back(mk(0, 3, 4'h0, 32'h0, 0, 1, 32'hC003_BEEF, 2));
    run_until_idle(100);

    // Randomized traffic from both requesters over a small address window
    for (int i = 0; i < 80; i++) begin
      for (int r = 0; r < 2; r++) begin
        t.we    = 1'($urandom_range(0, 1));
        t.addr  = AW'($urandom_range(0, 7));
        case ($urandom_range(0, 3))
          0:       t.be = '0;
          1:       t.be = '1;
          default: t.be = BW'($urandom);
        endcase
        t.wdata   = $urandom;
        t.gap     = $urandom_range(0, 2);
        t.has_lit = 0; t.lit = '0; t.lit_lat = 0;
        if (r == 0) q0.push_back(t); else q1.push_back(t);
      end
    end
    run_until_idle(4000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
